pwm_frame_ctrl: RTL and testbench
=================================

# pwm_frame_ctrl

Frame-commit controller between the SPI frame receiver and the 8-channel PWM core. Double-buffers incoming duty-cycle frames in a shadow register and commits them to the PWM only at a PWM period boundary, so a channel never sees a mid-period duty change. An optional watchdog blanks all channels when the upstream host stops sending frames.

## Interface
- CHANNELS, 8: number of PWM channels
- WIDTH, 16: duty value width per channel
- TIMEOUT_CYCLES, 48_000_000: consecutive frame-free cycles before watchdog trip (1 s at 48 MHz HFOSC)
- clock  in  1  system clock (HFOSC)
- reset  in  1  asynchronous, active-high reset
- frame_valid  in  1  single-cycle pulse; frame_data valid this cycle
- frame_data  in  CHANNELS*WIDTH  packed duty values, channel 0 in bits [WIDTH-1:0]
- period_end  in  1  single-cycle pulse from PWM core at counter wrap
- active_data  out  CHANNELS*WIDTH  duty values driven to PWM core, same packing
- update_pulse  out  1  high for one cycle when active_data changes by commit or blank
- frame_dropped  out  1  one-cycle pulse when an uncommitted shadow frame is overwritten
- timeout  out  1  watchdog tripped; held until next frame commit

## Operation
- States: IDLE (no pending frame), PENDING (shadow holds uncommitted frame), BLANK_WAIT (watchdog tripped, waiting for boundary), BLANKED (outputs zeroed).
- IDLE + frame_valid -> shadow <= frame_data, PENDING. No bypass: commit always waits for a period_end strictly after capture.
- PENDING + period_end -> active_data <= shadow, update_pulse, timeout <= 0, IDLE.
- PENDING + frame_valid (no period_end) -> shadow overwritten, frame_dropped pulse, stay PENDING.
- PENDING + frame_valid + period_end same cycle -> old shadow committed to active; new frame_data loaded into shadow; stay PENDING; no frame_dropped.
- IDLE + period_end -> no action.
- Watchdog: counter clears on frame_valid, else increments, saturating. Trip when count reaches TIMEOUT_CYCLES-1 with no frame_valid that cycle (i.e. after TIMEOUT_CYCLES frame-free cycles): timeout <= 1, any pending shadow discarded, BLANK_WAIT. Counter frozen in BLANK_WAIT/BLANKED.
- BLANK_WAIT + period_end -> active_data <= 0, update_pulse, BLANKED.
- BLANK_WAIT or BLANKED + frame_valid -> shadow loaded, counter cleared, PENDING; timeout stays 1 until that frame commits.
- BLANK_WAIT + frame_valid + period_end same cycle -> blank applied this boundary, new frame pending.
- Counter width $clog2(TIMEOUT_CYCLES+1); TIMEOUT_CYCLES >= 2.

## Timing
- All outputs registered. Reset values: active_data 0, update_pulse 0, frame_dropped 0, timeout 0; shadow 0, counter 0, state IDLE.
- Commit latency: frame_valid at cycle t, first period_end at t+k (k >= 1) -> new active_data and update_pulse visible at t+k+1.
- frame_dropped asserted cycle after the overwriting frame_valid.
- Reset asserted mid-operation: immediate return to reset values; pending frame lost.

## Configuration
- PWM_FRAME_WATCHDOG_EN defined: watchdog counter and BLANK_WAIT/BLANKED states present, behaviour as above.
- Undefined: counter not instantiated, timeout tied 0, frames never discarded, active_data holds last committed frame indefinitely.

## Structure
- Package pwm_ctrl_pkg: state enum, default CHANNELS/WIDTH/TIMEOUT_CYCLES constants, packed-frame width constant.
- One sub-module: pwm_watchdog (clear, saturating count, single-cycle expire output), instantiated only under PWM_FRAME_WATCHDOG_EN.

## Test plan
- Reset then frame_valid with ch0=0x1234, ch7=0xFFFF, period_end 5 cycles later -> active_data ch0=0x1234, ch7=0xFFFF and update_pulse one cycle after period_end.
- Two frame_valid (A then B) before any period_end -> frame_dropped once; commit yields B.
- frame_valid(C) and period_end same cycle while A pending -> A committed that boundary, C committed at next period_end, no frame_dropped.
- TIMEOUT_CYCLES=20, no frames -> timeout rises at cycle 21 after last frame; active_data zero one cycle after next period_end; update_pulse once.
- While BLANKED, frame_valid(D) then period_end -> active_data=D, timeout falls with update_pulse.
- Reset asserted while PENDING -> active_data 0, state IDLE; subsequent period_end produces no update_pulse.

Source files
------------

// File: rtl/pwm_ctrl_pkg.sv
// Shared types and default sizing for the PWM frame-commit controller.
package pwm_ctrl_pkg;

  localparam int CHANNELS_DEF       = 8;
  localparam int WIDTH_DEF          = 16;
  localparam int TIMEOUT_CYCLES_DEF = 48_000_000;
  localparam int FRAME_W_DEF        = CHANNELS_DEF * WIDTH_DEF;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PENDING    = 2'd1,
    ST_BLANK_WAIT = 2'd2,
    ST_BLANKED    = 2'd3
  } frame_state_e;

endpackage

// File: rtl/pwm_watchdog.sv
// Frame-activity watchdog: counts frame-free cycles and flags expiry for one cycle.
// Only instantiated when PWM_FRAME_WATCHDOG_EN is defined.
module pwm_watchdog
  import pwm_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] SAT  = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_run && (r_count != SAT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Expiry is the TIMEOUT_CYCLES-th consecutive frame-free cycle.
  assign o_expire = i_run && !i_clear && (r_count == TERM);

endmodule

// File: rtl/pwm_frame_ctrl.sv
// Double-buffered duty frame commit at PWM period boundaries.
// Optional watchdog blanking enabled by defining PWM_FRAME_WATCHDOG_EN.
//
// state         | meaning
// ST_IDLE       | no pending frame; active_data holds last commit
// ST_PENDING    | shadow holds an uncommitted frame
// ST_BLANK_WAIT | watchdog tripped; blank at next period boundary
// ST_BLANKED    | outputs zeroed until a new frame arrives
module pwm_frame_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int CHANNELS       = CHANNELS_DEF,
  parameter int WIDTH          = WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_frame_valid,
  input  logic [CHANNELS*WIDTH-1:0] i_frame_data,
  input  logic                      i_period_end,
  output logic [CHANNELS*WIDTH-1:0] o_active_data,
  output logic                      o_update_pulse,
  output logic                      o_frame_dropped,
  output logic                      o_timeout
);

  localparam int FRAME_W = CHANNELS * WIDTH;

  frame_state_e r_state;
  frame_state_e w_state_nxt;

  logic [FRAME_W-1:0] r_shadow;
  logic [FRAME_W-1:0] r_active;
  logic               r_update;
  logic               r_dropped;

  logic w_expire;
  logic w_commit;
  logic w_blank;
  logic w_drop;

`ifdef PWM_FRAME_WATCHDOG_EN
  logic w_wd_run;
  logic r_timeout;

  assign w_wd_run = (r_state == ST_IDLE) || (r_state == ST_PENDING);

  pwm_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clear (i_frame_valid),
    .i_run   (w_wd_run),
    .o_expire(w_expire)
  );

  // Timeout holds through blanking and any later pending frame until it commits.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_timeout <= 1'b0;
    end else if (w_expire) begin
      r_timeout <= 1'b1;
    end else if (w_commit) begin
      r_timeout <= 1'b0;
    end
  end

  assign o_timeout = r_timeout;
`else
  assign w_expire  = 1'b0;
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_expire)           w_state_nxt = ST_BLANK_WAIT;
        else if (i_frame_valid) w_state_nxt = ST_PENDING;
      end
      ST_PENDING: begin
        if (w_expire)           w_state_nxt = ST_BLANK_WAIT;
        else if (i_frame_valid) w_state_nxt = ST_PENDING;
        else if (i_period_end)  w_state_nxt = ST_IDLE;
      end
      ST_BLANK_WAIT: begin
        if (i_frame_valid)     w_state_nxt = ST_PENDING;
        else if (i_period_end) w_state_nxt = ST_BLANKED;
      end
      ST_BLANKED: begin
        if (i_frame_valid) w_state_nxt = ST_PENDING;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A trip discards the pending frame, so it wins over a same-cycle commit.
  always_comb begin
    w_commit = (r_state == ST_PENDING) && i_period_end && !w_expire;
    w_blank  = (r_state == ST_BLANK_WAIT) && i_period_end;
    w_drop   = (r_state == ST_PENDING) && i_frame_valid && !i_period_end;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_shadow  <= '0;
      r_active  <= '0;
      r_update  <= 1'b0;
      r_dropped <= 1'b0;
    end else begin
      if (i_frame_valid) begin
        r_shadow <= i_frame_data;
      end
      if (w_commit) begin
        r_active <= r_shadow;
      end else if (w_blank) begin
        r_active <= '0;
      end
      r_update  <= w_commit || w_blank;
      r_dropped <= w_drop;
    end
  end

  assign o_active_data   = r_active;
  assign o_update_pulse  = r_update;
  assign o_frame_dropped = r_dropped;

endmodule

// File: tb/tb_pwm_frame_ctrl.sv
// Self-checking bench for pwm_frame_ctrl: directed scenarios plus randomized traffic
// against a queue-based reference model. Watchdog checks follow PWM_FRAME_WATCHDOG_EN.
module tb_pwm_frame_ctrl;

  localparam int CH = 8;
  localparam int W  = 16;
  localparam int T  = 20;
  localparam int FW = CH * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          fv;
  logic          pe;
  logic [FW-1:0] fd;
  logic [FW-1:0] o_active_data;
  logic          o_update_pulse;
  logic          o_frame_dropped;
  logic          o_timeout;

  always #5 clk = ~clk;

  pwm_frame_ctrl #(
    .CHANNELS(CH),
    .WIDTH(W),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_frame_valid  (fv),
    .i_frame_data   (fd),
    .i_period_end   (pe),
    .o_active_data  (o_active_data),
    .o_update_pulse (o_update_pulse),
    .o_frame_dropped(o_frame_dropped),
    .o_timeout      (o_timeout)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a one-deep queue of uncommitted frames, a blank request,
  // and a count of consecutive frame-free cycles.
  logic [FW-1:0] q_pend[$];
  logic [FW-1:0] m_active;
  bit            m_update;
  bit            m_drop;
  bit            m_timeout;
  bit            m_blank_req;
  bit            m_frozen;
  int            m_quiet;

  task automatic check(string tag, logic [FW-1:0] obs, logic [FW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_pend.delete();
    m_active    = '0;
    m_update    = 0;
    m_drop      = 0;
    m_timeout   = 0;
    m_blank_req = 0;
    m_frozen    = 0;
    m_quiet     = 0;
  endtask

  task automatic model_step(bit v, logic [FW-1:0] d, bit p);
    bit trip;
    trip = 0;
`ifdef PWM_FRAME_WATCHDOG_EN
    trip = !m_frozen && !v && (m_quiet + 1 == T);
`endif
    m_update = 0;
    m_drop   = 0;
    if (trip) begin
      q_pend.delete();
      m_blank_req = 1;
      m_frozen    = 1;
      m_timeout   = 1;
    end else begin
      if (v && !p && q_pend.size() != 0) m_drop = 1;
      if (p && q_pend.size() != 0) begin
        m_active  = q_pend.pop_front();
        m_update  = 1;
        m_timeout = 0;
      end
      if (p && m_blank_req) begin
        m_active    = '0;
        m_update    = 1;
        m_blank_req = 0;
      end
      if (v) begin
        q_pend.delete();
        q_pend.push_back(d);
        m_blank_req = 0;
        m_frozen    = 0;
        m_quiet     = 0;
      end else if (!m_frozen) begin
        m_quiet++;
      end
    end
  endtask

  task automatic check_outputs(string tag);
    check({tag, ":active"},  o_active_data,       m_active);
    check({tag, ":update"},  FW'(o_update_pulse),  FW'(m_update));
    check({tag, ":dropped"}, FW'(o_frame_dropped), FW'(m_drop));
    check({tag, ":timeout"}, FW'(o_timeout),       FW'(m_timeout));
  endtask

  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] r;
    for (int i = 0; i < FW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic step(string tag, bit v, logic [FW-1:0] d, bit p);
    fv = v;
    fd = d;
    pe = p;
    @(posedge clk);
    model_step(v, d, p);
    #1;
    fv = 1'b0;
    pe = 1'b0;
    check_outputs(tag);
  endtask

  task automatic idle(string tag, int n);
    for (int i = 0; i < n; i++) step(tag, 0, rand_frame(), 0);
  endtask

  task automatic do_reset(string tag);
    rst = 1'b1;
    fv  = 1'b0;
    pe  = 1'b0;
    model_reset();
    #2;
    check_outputs(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [FW-1:0] fa, fb, fc, fdd, fe;

  initial begin
    rst = 1'b1;
    fv  = 1'b0;
    pe  = 1'b0;
    fd  = '0;
    model_reset();
    #2;
    check_outputs("reset");
    check("reset_active_zero", o_active_data, '0);
    @(negedge clk);
    rst = 1'b0;

    // Basic commit with a 5-cycle gap to the boundary.
    fa = rand_frame();
    fa[15:0]   = 16'h1234;
    fa[127:112] = 16'hFFFF;
    step("t1_cap", 1, fa, 0);
    idle("t1_wait", 4);
    check("t1_no_early", FW'(o_update_pulse), '0);
    step("t1_pe", 0, rand_frame(), 1);
    check("t1_ch0", FW'(o_active_data[15:0]), FW'(16'h1234));
    check("t1_ch7", FW'(o_active_data[127:112]), FW'(16'hFFFF));
    check("t1_upd", FW'(o_update_pulse), FW'(1'b1));
    step("t1_after", 0, rand_frame(), 0);

    // Overwrite before boundary: one drop, B wins.
    fa = rand_frame();
    fb = rand_frame();
    step("t2_a", 1, fa, 0);
    step("t2_b", 1, fb, 0);
    check("t2_drop", FW'(o_frame_dropped), FW'(1'b1));
    step("t2_pe", 0, rand_frame(), 1);
    check("t2_commit_b", o_active_data, fb);

    // Same-cycle frame and boundary: A commits, C stays pending.
    fa = rand_frame();
    fc = rand_frame();
    step("t3_a", 1, fa, 0);
    step("t3_c_pe", 1, fc, 1);
    check("t3_commit_a", o_active_data, fa);
    check("t3_no_drop", FW'(o_frame_dropped), '0);
    step("t3_pe2", 0, rand_frame(), 1);
    check("t3_commit_c", o_active_data, fc);

    // Quiet period: 20 frame-free cycles since frame C (one already elapsed).
    idle("t4_quiet", 18);
    check("t4_no_trip_yet", FW'(o_timeout), '0);
    idle("t4_trip", 1);
`ifdef PWM_FRAME_WATCHDOG_EN
    check("t4_timeout", FW'(o_timeout), FW'(1'b1));
    check("t4_active_held", o_active_data, fc);
    step("t4_blank", 0, rand_frame(), 1);
    check("t4_blank_zero", o_active_data, '0);
    check("t4_blank_upd", FW'(o_update_pulse), FW'(1'b1));
`else
    check("t4_timeout", FW'(o_timeout), '0);
    step("t4_pe", 0, rand_frame(), 1);
    check("t4_active_held", o_active_data, fc);
`endif
    step("t4_pe2", 0, rand_frame(), 1);
    check("t4_single_upd", FW'(o_update_pulse), '0);

    // Recovery with a new frame.
    fdd = rand_frame();
    step("t5_d", 1, fdd, 0);
    idle("t5_wait", 1);
    step("t5_pe", 0, rand_frame(), 1);
    check("t5_active_d", o_active_data, fdd);
    check("t5_timeout_clr", FW'(o_timeout), '0);
    check("t5_upd", FW'(o_update_pulse), FW'(1'b1));

    // Reset while a frame is pending.
    fe = rand_frame();
    step("t6_e", 1, fe, 0);
    #3;
    do_reset("t6_reset");
    check("t6_active_zero", o_active_data, '0);
    step("t6_pe", 0, rand_frame(), 1);
    check("t6_no_upd", FW'(o_update_pulse), '0);

    // Randomized traffic in segments of varying frame density.
    for (int seg = 0; seg < 40; seg++) begin
      int rate;
      rate = (seg % 3 == 0) ? 3 : ((seg % 3 == 1) ? 30 : 1000);
      for (int i = 0; i < 80; i++) begin
        if ($urandom_range(0, 599) == 0) begin
          #2;
          do_reset("rnd_reset");
        end else begin
          step("rnd", ($urandom_range(0, rate - 1) == 0), rand_frame(),
               ($urandom_range(0, 5) == 0));
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
